// File: rtl/q11_seq_right_shifter_pkg.sv
// Shared definitions for the sequential right shifter and its selector decoder.
package q11_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/q11_seq_right_shifter_if.sv
// Request/result bundle between a requester and the sequential right shifter.
interface q11_seq_right_shifter_if #(
    parameter int W = 8
);

    logic         start;
    logic [W-1:0] din;
    logic [W-1:0] n;
    logic         ready;
    logic         done;
    logic [W-1:0] dout;
    logic         sticky;
    logic         err;

    modport master (
        output start, din, n,
        input  ready, done, dout, sticky, err
    );

    modport slave (
        input  start, din, n,
        output ready, done, dout, sticky, err
    );

endinterface

// File: rtl/q11_seq_right_shifter_onehot_idx.sv
// One-hot selector decoder: bit index of the set bit, plus a flag that exactly one bit is set.
module q11_onehot_idx
    import q11_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = CNT_W
) (
    input  logic [W-1:0]  sel,
    output logic [CW-1:0] idx,
    output logic          valid
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (sel[i]) begin
                idx = CW'(i);
            end
        end
        // A power of two has no bits in common with itself minus one.
        valid = (sel != '0) && ((sel & (sel - W'(1))) == '0);
    end

endmodule

// File: rtl/q11_seq_right_shifter.sv
// Sequential logical right shifter: one bit per clock, sticky OR of the bits lost off the LSB.
module q11_seq_right_shifter
    import q11_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    q11_seq_right_shifter_if.slave   bus
);

    localparam int CW = $clog2(W);

    state_e        state_q,  state_d;
    logic [W-1:0]  data_q,   data_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          sticky_q, sticky_d;
    logic          err_q,    err_d;
    logic          ready_q,  ready_d;
    logic          done_q,   done_d;

    logic [CW-1:0] sel_idx;
    logic          sel_valid;

    q11_onehot_idx #(
        .W  (W),
        .CW (CW)
    ) u_onehot_idx (
        .sel   (bus.n),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sticky_d = 1'b0;
                    if (sel_valid) begin
                        data_d  = bus.din;
                        cnt_d   = sel_idx;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    data_d   = {1'b0, data_q[W-1:1]};
                    sticky_d = sticky_q | data_q[0];
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status flags registered from the next state so they depend on state alone.
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            // NOTE: the data register is a plain flop, not a memory, so it is reset to keep dout defined.
            data_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.dout   = data_q;
    assign bus.sticky = sticky_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_q11_seq_right_shifter.sv
// Directed bench with a transaction-level reference model and a per-cycle compare process.
module tb_q11_seq_right_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    q11_seq_right_shifter_if #(.W(8)) bus ();

    q11_seq_right_shifter #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: works per transaction (result = din >> k, done at a computed cycle).
    bit         m_init   = 1'b0;
    bit         m_idle   = 1'b1;
    int         m_done_c = -1;
    logic [7:0] m_dout   = '0;
    logic       m_sticky = 1'b0;
    logic       m_err    = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init   = 1'b1;
            m_idle   = 1'b1;
            m_done_c = -1;
            m_dout   = '0;
            m_sticky = 1'b0;
            m_err    = 1'b0;
        end else if (m_idle && bus.start) begin
            int k;
            k = 0;
            for (int i = 0; i < 8; i++) if (bus.n[i]) k = i;
            m_idle = 1'b0;
            if ($countones(bus.n) == 1) begin
                m_dout   = bus.din >> k;
                m_sticky = ((int'(bus.din) % (1 << k)) != 0);
                m_err    = 1'b0;
                m_done_c = cyc + k + 1;
            end else begin
                m_dout   = '0;
                m_sticky = 1'b0;
                m_err    = 1'b1;
                m_done_c = cyc;
            end
        end else if (!m_idle && cyc == m_done_c + 1) begin
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            logic exp_done;
            exp_done = !m_idle && (cyc == m_done_c);
            check("ready", 32'(bus.ready), 32'(m_idle));
            check("done",  32'(bus.done),  32'(exp_done));
            if (m_idle || exp_done) begin
                check("dout",   32'(bus.dout),   32'(m_dout));
                check("sticky", 32'(bus.sticky), 32'(m_sticky));
                check("err",    32'(bus.err),    32'(m_err));
            end
        end
    end

    int last_start = 0;

    // Called at a negedge; issues one request and checks hand-computed results at done.
    task automatic run_op(input string nm, input logic [7:0] d, input logic [7:0] sel,
                          input logic [7:0] e_dout, input logic e_st, input logic e_err,
                          input int e_lat, input bit poke);
        int sc;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.din = d; bus.n = sel;
        sc = cyc;
        @(negedge clk);
        bus.start = 1'b0; bus.din = '0; bus.n = '0;
        if (poke) begin
            @(negedge clk);
            bus.start = 1'b1; bus.din = 8'hAA; bus.n = 8'h01;
            @(negedge clk);
            bus.start = 1'b0; bus.din = '0; bus.n = '0;
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_latency"}, 32'(cyc - sc), 32'(e_lat));
        check({nm, "_dout"},   32'(bus.dout),   32'(e_dout));
        check({nm, "_sticky"}, 32'(bus.sticky), 32'(e_st));
        check({nm, "_err"},    32'(bus.err),    32'(e_err));
        last_start = sc;
    endtask

    initial begin
        int first_start;
        int done_cnt;
        bus.start = 1'b0; bus.din = '0; bus.n = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        repeat (5) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.ready), 32'd1);
            check("idle_dout",  32'(bus.dout),  32'd0);
        end

        run_op("k2",    8'b1011_0100, 8'b0000_0100, 8'b0010_1101, 1'b0, 1'b0, 4, 1'b0);
        run_op("k7",    8'hFF, 8'h80, 8'h01, 1'b1, 1'b0, 9, 1'b0);
        run_op("n00",   8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 1, 1'b0);
        run_op("n24",   8'h5A, 8'h24, 8'h00, 1'b0, 1'b1, 1, 1'b0);
        run_op("k0",    8'hC3, 8'h01, 8'hC3, 1'b0, 1'b0, 2, 1'b0);

        // Ignored start during SHIFT, then back-to-back issue the cycle ready returns.
        run_op("poke",  8'h0F, 8'h08, 8'h01, 1'b1, 1'b0, 5, 1'b1);
        first_start = last_start;
        run_op("b2b",   8'h80, 8'h10, 8'h08, 1'b0, 1'b0, 6, 1'b0);
        check("b2b_spacing", 32'(last_start - first_start), 32'd6);

        // Mid-operation reset aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.din = 8'hF0; bus.n = 8'h20;
        @(negedge clk);
        bus.start = 1'b0; bus.din = '0; bus.n = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_dout",  32'(bus.dout),  32'd0);
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        run_op("k1_after_rst", 8'h03, 8'h02, 8'h01, 1'b1, 1'b0, 3, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
